// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/data requesters, the arbiter and the RAM.
// master is the arbiter's view; slave is the surrounding system's view.
interface mem_arbiter_if;
  logic        imemREN;
  logic [31:0] imemaddr;
  logic [31:0] imemload;
  logic        iready;
  logic        dmemREN;
  logic        dmemWEN;
  logic [31:0] dmemaddr;
  logic [31:0] dmemstore;
  logic [31:0] dmemload;
  logic        dready;
  logic        err;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  logic        busy_o;

  modport master (
    input  imemREN, imemaddr,
    input  dmemREN, dmemWEN, dmemaddr, dmemstore,
    input  ramload, busy_o,
    output imemload, iready,
    output dmemload, dready, err,
    output ramREN, ramWEN, ramaddr, ramstore
  );

  modport slave (
    output imemREN, imemaddr,
    output dmemREN, dmemWEN, dmemaddr, dmemstore,
    output ramload, busy_o,
    input  imemload, iready,
    input  dmemload, dready, err,
    input  ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the shared single-ported RAM.
// Data wins unless fetch has starved; hung accesses time out with an error.
module mem_arbiter #(
  parameter int          STARVE_LIMIT = 4,
  parameter int          TIMEOUT      = 64,
  parameter logic [31:0] ERR_WORD     = 32'hDEADBEEF
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.master bus
);

  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, I_RD, D_RD, D_WR, RESP
  } state_t;

  state_t        state, next;
  logic [31:0]   addr_q, store_q;
  logic          port_d;
  logic          abort_q;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] timer;

  logic dreq, force_i;
  logic grant_d, grant_i;
  logic access, abort_now, fin;

  assign dreq      = bus.dmemREN | bus.dmemWEN;
  assign force_i   = bus.imemREN &&
                     (starve_cnt == SW'(STARVE_LIMIT));
  assign access    = (state == I_RD) ||
                     (state == D_RD) ||
                     (state == D_WR);
  assign abort_now = bus.busy_o &&
                     (timer == TW'(TIMEOUT - 1));
  assign fin       = !bus.busy_o || abort_now;

  assign bus.ramaddr  = addr_q;
  assign bus.ramstore = store_q;

  always_comb begin
    next       = state;
    grant_d    = 1'b0;
    grant_i    = 1'b0;
    bus.ramREN = 1'b0;
    bus.ramWEN = 1'b0;
    bus.iready = 1'b0;
    bus.dready = 1'b0;
    bus.err    = 1'b0;
    unique case (state)
      IDLE: begin
        if (dreq && !force_i) begin
          grant_d = 1'b1;
          next    = bus.dmemWEN ? D_WR : D_RD;
        end else if (bus.imemREN) begin
          grant_i = 1'b1;
          next    = I_RD;
        end
      end
      I_RD, D_RD: begin
        bus.ramREN = 1'b1;
        if (fin) next = RESP;
      end
      D_WR: begin
        bus.ramWEN = 1'b1;
        if (fin) next = RESP;
      end
      RESP: begin
        bus.iready = !port_d;
        bus.dready = port_d;
        bus.err    = abort_q;
        next       = IDLE;
      end
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      addr_q       <= '0;
      store_q      <= '0;
      port_d       <= 1'b0;
      abort_q      <= 1'b0;
      starve_cnt   <= '0;
      timer        <= '0;
      bus.imemload <= '0;
      bus.dmemload <= '0;
    end else begin
      if (grant_d) begin
        addr_q  <= bus.dmemaddr;
        port_d  <= 1'b1;
        abort_q <= 1'b0;
        timer   <= '0;
        if (bus.dmemWEN) store_q <= bus.dmemstore;
        // Count only grants that actually made a fetch wait.
        if (!bus.imemREN)
          starve_cnt <= '0;
        else if (starve_cnt != SW'(STARVE_LIMIT))
          starve_cnt <= starve_cnt + SW'(1);
      end else if (grant_i) begin
        addr_q     <= bus.imemaddr;
        port_d     <= 1'b0;
        abort_q    <= 1'b0;
        timer      <= '0;
        starve_cnt <= '0;
      end
      if (access) begin
        if (bus.busy_o) timer <= timer + TW'(1);
        if (abort_now) abort_q <= 1'b1;
        if (state == I_RD && fin)
          bus.imemload <= abort_now ? ERR_WORD : bus.ramload;
        if (state == D_RD && fin)
          bus.dmemload <= abort_now ? ERR_WORD : bus.ramload;
      end
    end
  end

endmodule
